// File: rtl/ctrl_fsm.sv
// Multi-cycle instruction controller: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// bounded memory-ack wait, a compare flag for branches and a saturating retire count.
module ctrl_fsm #(
  parameter int IW       = 9,
  parameter int RW       = 3,
  parameter int MAX_WAIT = 15,
  parameter int CW       = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          start,
  input  logic [IW-1:0] inst_in,
  input  logic          ZERO,
  input  logic          mem_ack,
  output logic [RW-1:0] rAddrA,
  output logic [RW-1:0] rAddrB,
  output logic [RW-1:0] wAddr,
  output logic          write_en,
  output logic          ReadMem,
  output logic          WriteMem,
  output logic          jump_en,
  output logic          branch_en,
  output logic          pc_next,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    OP_ALUR  = 3'b000, OP_ALUI = 3'b001, OP_LOAD = 3'b010, OP_STORE = 3'b011,
    OP_JUMP  = 3'b100, OP_CMP  = 3'b101, OP_BRE  = 3'b110, OP_HALT  = 3'b111
  } op_t;

  localparam int            WW        = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);
  localparam logic [WW-1:0] WAIT_ONE  = WW'(1);
  localparam logic [CW-1:0] RET_ONE   = CW'(1);

  state_t        r_state;
  logic [IW-1:0] r_ir;
  logic          r_flag;
  logic [WW-1:0] r_wait;
  logic [CW-1:0] r_retired;
  logic          r_done;
  logic          r_err;

  state_t        w_next;
  op_t           w_op;
  logic          w_fields_vis;
  logic          w_timeout;

  assign w_op = op_t'(r_ir[IW-1:IW-3]);

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    w_next    = r_state;
    write_en  = 1'b0;
    ReadMem   = 1'b0;
    WriteMem  = 1'b0;
    jump_en   = 1'b0;
    branch_en = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE:   if (start) w_next = S_FETCH;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: w_next = (w_op == OP_HALT) ? S_HALT : S_EXEC;
      S_EXEC: begin
        jump_en   = (w_op == OP_JUMP);
        branch_en = (w_op == OP_BRE) && r_flag;
        case (w_op)
          OP_LOAD, OP_STORE: w_next = S_MEM;
          OP_ALUR, OP_ALUI:  w_next = S_WB;
          default:           w_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        ReadMem  = (w_op == OP_LOAD);
        WriteMem = (w_op == OP_STORE);
        if (mem_ack) begin
          w_next = (w_op == OP_LOAD) ? S_WB : S_FETCH;
        end else if (r_wait == WAIT_LAST) begin
          // An ack on the final allowed cycle takes the branch above and still succeeds.
          w_timeout = 1'b1;
          w_next    = S_HALT;
        end
      end
      S_WB: begin
        write_en = 1'b1;
        w_next   = S_FETCH;
      end
      S_HALT:   if (start) w_next = S_FETCH;
      default:  w_next = S_IDLE;
    endcase
  end

  assign w_fields_vis = (r_state == S_DECODE) || (r_state == S_EXEC) ||
                        (r_state == S_MEM)    || (r_state == S_WB);

  // Only an instruction finishing (not a start out of IDLE/HALT) advances the PC.
  assign pc_next = (w_next == S_FETCH) &&
                   ((r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB));

  assign rAddrA  = w_fields_vis ? r_ir[2*RW-1:RW] : '0;
  assign wAddr   = w_fields_vis ? r_ir[2*RW-1:RW] : '0;
  assign rAddrB  = w_fields_vis ? r_ir[RW-1:0]    : '0;
  assign done    = r_done;
  assign err     = r_err;
  assign retired = r_retired;

  // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state   <= S_IDLE;
      r_ir      <= '0;
      r_flag    <= 1'b0;
      r_wait    <= '0;
      r_retired <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH) r_ir <= inst_in;
      if ((r_state == S_EXEC) && (w_op == OP_CMP)) r_flag <= ZERO;

      if (r_state == S_EXEC) begin
        r_wait <= '0;
      end else if ((r_state == S_MEM) && !mem_ack) begin
        r_wait <= r_wait + WAIT_ONE;
      end

      if (pc_next && (r_retired != '1)) r_retired <= r_retired + RET_ONE;

      if ((r_state == S_DECODE) && (w_op == OP_HALT)) begin
        r_done <= 1'b1;
      end else if ((r_state == S_HALT) && start) begin
        r_done <= 1'b0;
      end

      if (w_timeout) begin
        r_err <= 1'b1;
      end else if (((r_state == S_IDLE) || (r_state == S_HALT)) && start) begin
        r_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ctrl_fsm.sv
// Bench for ctrl_fsm: per-instruction expectation generator feeding a queue,
// one negedge compare process, plus literal spot checks; a CW=2 twin checks saturation.
module tb_ctrl_fsm;
  localparam int MW = 15;

  logic       Clk = 1'b0, Reset = 1'b0, start = 1'b0, ZERO = 1'b0, mem_ack = 1'b0;
  logic [8:0] inst_in = '0;

  logic [2:0]  rAddrA, rAddrB, wAddr;
  logic        write_en, ReadMem, WriteMem, jump_en, branch_en, pc_next, done, err;
  logic [15:0] retired;

  logic [2:0]  rAddrA2, rAddrB2, wAddr2;
  logic        write_en2, ReadMem2, WriteMem2, jump_en2, branch_en2, pc_next2, done2, err2;
  logic [1:0]  retired2;

  ctrl_fsm dut (
    .Clk(Clk), .Reset(Reset), .start(start), .inst_in(inst_in), .ZERO(ZERO), .mem_ack(mem_ack),
    .rAddrA(rAddrA), .rAddrB(rAddrB), .wAddr(wAddr), .write_en(write_en), .ReadMem(ReadMem),
    .WriteMem(WriteMem), .jump_en(jump_en), .branch_en(branch_en), .pc_next(pc_next),
    .done(done), .err(err), .retired(retired)
  );

  ctrl_fsm #(.CW(2)) dut2 (
    .Clk(Clk), .Reset(Reset), .start(start), .inst_in(inst_in), .ZERO(ZERO), .mem_ack(mem_ack),
    .rAddrA(rAddrA2), .rAddrB(rAddrB2), .wAddr(wAddr2), .write_en(write_en2), .ReadMem(ReadMem2),
    .WriteMem(WriteMem2), .jump_en(jump_en2), .branch_en(branch_en2), .pc_next(pc_next2),
    .done(done2), .err(err2), .retired(retired2)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [2:0]  ra, rb, wa;
    logic        we, rd, wr, jmp, br, pcn, done, err;
    logic [15:0] ret;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_cmp = 0, n_bad = 0;

  // Architectural model state: retired count, compare flag, done/err status.
  int   m_ret = 0;
  bit   m_flag = 1'b0, m_done = 1'b0, m_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  function automatic exp_t mk(input bit vis, input logic [8:0] ir, input bit we, input bit rd,
                              input bit wr, input bit jmp, input bit br, input bit pcn);
    exp_t e;
    e.ra   = vis ? ir[5:3] : 3'd0;
    e.rb   = vis ? ir[2:0] : 3'd0;
    e.wa   = e.ra;
    e.we   = we;  e.rd = rd;  e.wr = wr;
    e.jmp  = jmp; e.br = br;  e.pcn = pcn;
    e.done = m_done;
    e.err  = m_err;
    e.ret  = 16'(m_ret);
    return e;
  endfunction

  task automatic cyc(input bit st, input logic [8:0] inst, input bit z, input bit ack, input exp_t e);
    start   = st;
    inst_in = inst;
    ZERO    = z;
    mem_ack = ack;
    exp_q.push_back(e);
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b0, 9'($urandom), 1'($urandom), 1'b1, mk(1'b0, 9'd0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic kick();
    cyc(1'b1, 9'($urandom), 1'b0, 1'b0, mk(1'b0, 9'd0, 0, 0, 0, 0, 0, 0));
    m_done = 1'b0;
    m_err  = 1'b0;
  endtask

  // One instruction from its FETCH cycle; ack_delay = MEM cycles before the ack cycle,
  // abort_after >= 0 returns leaving the DUT in that MEM cycle. start is pulsed in EXEC.
  task automatic run_inst(input logic [8:0] inst, input bit z, input int ack_delay,
                          input int abort_after);
    logic [2:0] op;
    bit         ack;
    op = inst[8:6];
    cyc(1'b0, inst, z, 1'b0, mk(1'b0, inst, 0, 0, 0, 0, 0, 0));
    cyc(1'b0, ~inst, z, 1'b0, mk(1'b1, inst, 0, 0, 0, 0, 0, 0));
    if (op == 3'b111) begin
      m_done = 1'b1;
      return;
    end
    cyc(1'b1, ~inst, z, 1'b0, mk(1'b1, inst, 0, 0, 0, op == 3'b100, (op == 3'b110) && m_flag,
                                  op >= 3'b100));
    if (op == 3'b101) m_flag = z;
    if (op >= 3'b100) begin
      m_ret++;
      return;
    end
    if (op == 3'b010 || op == 3'b011) begin
      for (int k = 0; k < MW; k++) begin
        if (k == abort_after) return;
        ack = (k == ack_delay);
        cyc(1'b0, ~inst, z, ack, mk(1'b1, inst, 0, op == 3'b010, op == 3'b011, 0, 0,
                                      ack && (op == 3'b011)));
        if (ack) begin
          if (op == 3'b011) begin
            m_ret++;
            return;
          end
          break;
        end
        if (k == MW - 1) begin
          m_err = 1'b1;
          return;
        end
      end
    end
    cyc(1'b0, ~inst, z, 1'b0, mk(1'b1, inst, 1, 0, 0, 0, 0, 1));
    m_ret++;
  endtask

  always @(negedge Clk) begin
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      check("rAddrA",    32'(rAddrA),    32'(cur.ra));
      check("rAddrB",    32'(rAddrB),    32'(cur.rb));
      check("wAddr",     32'(wAddr),     32'(cur.wa));
      check("write_en",  32'(write_en),  32'(cur.we));
      check("ReadMem",   32'(ReadMem),   32'(cur.rd));
      check("WriteMem",  32'(WriteMem),  32'(cur.wr));
      check("jump_en",   32'(jump_en),   32'(cur.jmp));
      check("branch_en", 32'(branch_en), 32'(cur.br));
      check("pc_next",   32'(pc_next),   32'(cur.pcn));
      check("done",      32'(done),      32'(cur.done));
      check("err",       32'(err),       32'(cur.err));
      check("retired",   32'(retired),   32'(cur.ret));
      check("cw2_ctrl",
            32'({rAddrA2, rAddrB2, wAddr2, write_en2, ReadMem2, WriteMem2, jump_en2,
                 branch_en2, pc_next2, done2, err2}),
            32'({cur.ra, cur.rb, cur.wa, cur.we, cur.rd, cur.wr, cur.jmp,
                 cur.br, cur.pcn, cur.done, cur.err}));
      check("cw2_retired", 32'(retired2), (cur.ret > 16'd3) ? 32'd3 : 32'(cur.ret));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of stimulus, expected completion before 100000");
    $fatal(1);
  end

  initial begin
    #2;
    check("reset_outputs_zero",
          32'({rAddrA, rAddrB, wAddr, write_en, ReadMem, WriteMem, jump_en, branch_en,
               pc_next, done, err, retired}), 32'd0);
    @(posedge Clk); #1;
    Reset = 1'b1;
    idle(3);

    kick();
    run_inst(9'b000_010_011, 1'b0, 0, -1);
    check("lit_retired_alur", 32'(retired), 32'd1);
    run_inst(9'b001_101_110, 1'b1, 0, -1);
    run_inst(9'b101_000_000, 1'b1, 0, -1);
    run_inst(9'b110_001_111, 1'b0, 0, -1);
    run_inst(9'b101_011_001, 1'b0, 0, -1);
    run_inst(9'b110_010_100, 1'b1, 0, -1);
    run_inst(9'b100_111_001, 1'b0, 0, -1);
    run_inst(9'b010_100_001, 1'b0, 3, -1);
    run_inst(9'b011_011_010, 1'b0, 0, -1);
    run_inst(9'b010_110_101, 1'b0, MW - 1, -1);
    run_inst(9'b101_001_001, 1'b1, 0, -1);
    run_inst(9'b111_001_010, 1'b0, 0, -1);
    idle(2);
    check("lit_done_halt",      32'(done),     32'd1);
    check("lit_retired_halt",   32'(retired),  32'd11);
    check("lit_cw2_saturated",  32'(retired2), 32'd3);

    kick();
    run_inst(9'b010_010_010, 1'b0, 100, -1);
    idle(2);
    check("lit_err_timeout",     32'(err),     32'd1);
    check("lit_retired_timeout", 32'(retired), 32'd11);

    kick();
    check("lit_err_cleared", 32'(err), 32'd0);
    run_inst(9'b110_101_011, 1'b0, 0, -1);
    run_inst(9'b011_001_110, 1'b0, 2, -1);
    check("lit_retired_after_bre_store", 32'(retired), 32'd13);

    run_inst(9'b010_011_100, 1'b0, 100, 2);
    start   = 1'b0;
    mem_ack = 1'b0;
    #1;
    check("lit_readmem_before_reset", 32'(ReadMem), 32'd1);
    Reset = 1'b0;
    #1;
    check("lit_reset_mid_mem_zero",
          32'({rAddrA, rAddrB, wAddr, write_en, ReadMem, WriteMem, jump_en, branch_en,
               pc_next, done, err, retired, retired2}), 32'd0);
    m_ret  = 0;
    m_flag = 1'b0;
    m_done = 1'b0;
    m_err  = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b1;
    idle(3);
    check("lit_retired_after_reset", 32'(retired), 32'd0);

    kick();
    run_inst(9'b000_010_011, 1'b0, 0, -1);
    check("lit_retired_final", 32'(retired), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
